// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port memory with a registered read.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_t;

    state_t state;
    logic   cur_port;
    logic   cur_we;
    logic   any_req;
    logic   pick1;

`ifdef MEM_ARB_RR_EN
    // 1 = port 1 was granted most recently
    logic last_port;

    always_comb begin
        pick1 = req1 & (~req0 | ~last_port);
    end
`else
    always_comb begin
        pick1 = req1 & ~req0;
    end
`endif

    assign any_req = req0 | req1;
    assign busy    = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cur_port <= 1'b0;
            cur_we   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
`ifdef MEM_ARB_RR_EN
            last_port <= 1'b1;
`endif
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                StAccess: begin
                    state <= StResp;
                end
                StIdle, StResp: begin
                    // Completion of the previous transaction; mem_out is valid in RESP
                    if (state == StResp) begin
                        if (cur_port) begin
                            rvalid1 <= 1'b1;
                            if (!cur_we) rdata1 <= mem_out;
                        end else begin
                            rvalid0 <= 1'b1;
                            if (!cur_we) rdata0 <= mem_out;
                        end
                    end
                    if (any_req) begin
                        state    <= StAccess;
                        cur_port <= pick1;
                        cur_we   <= pick1 ? we1 : we0;
                        mem_we   <= pick1 ? we1 : we0;
                        mem_addr <= pick1 ? addr1 : addr0;
                        mem_data <= pick1 ? wdata1 : wdata0;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
`ifdef MEM_ARB_RR_EN
                        last_port <= pick1;
`endif
                    end else begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [15:0] rdata0, rdata1, mem_data, mem_out;
    logic [5:0]  mem_addr;

    logic [15:0] mem [64];
    logic        pre_en;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;

    int checks;
    int errors;

    mem_arbiter #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_out (mem_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        #2 rst_n = 1'b0;

        preload(6'h05, 16'h0009);
        preload(6'h10, 16'h1111);
        preload(6'h20, 16'h2222);

        // Reset state
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        rst_n = 1'b1;

        // Single read by port 0
        req0 = 1; we0 = 0; addr0 = 6'h05;
        step();
        check("rd_gnt0", gnt0, 1);
        check("rd_gnt1", gnt1, 0);
        check("rd_mem_addr", mem_addr, 6'h05);
        check("rd_mem_we", mem_we, 0);
        check("rd_busy", busy, 1);
        req0 = 0;
        step();
        check("rd_resp_gnt0", gnt0, 0);
        check("rd_resp_rvalid0", rvalid0, 0);
        check("rd_resp_addr", mem_addr, 6'h05);
        step();
        check("rd_rvalid0", rvalid0, 1);
        check("rd_rvalid1", rvalid1, 0);
        check("rd_rdata0", rdata0, 16'h0009);
        check("rd_idle_busy", busy, 0);
        step();
        check("rd_rvalid0_pulse", rvalid0, 0);

        // Port 1 write then back-to-back read of the same address
        req1 = 1; we1 = 1; addr1 = 6'h3F; wdata1 = 16'hABCD;
        step();
        check("wr_gnt1", gnt1, 1);
        check("wr_gnt0", gnt0, 0);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 6'h3F);
        check("wr_mem_data", mem_data, 16'hABCD);
        we1 = 0;
        step();
        check("wr_resp_mem_we", mem_we, 0);
        check("wr_resp_addr", mem_addr, 6'h3F);
        step();
        check("wr_rvalid1", rvalid1, 1);
        check("wr_rdata1_hold", rdata1, 0);
        check("rd2_gnt1", gnt1, 1);
        check("rd2_mem_we", mem_we, 0);
        req1 = 0;
        step();
        check("rd2_resp_rvalid1", rvalid1, 0);
        step();
        check("rd2_rvalid1", rvalid1, 1);
        check("rd2_rdata1", rdata1, 16'hABCD);
        check("rd2_rdata0_hold", rdata0, 16'h0009);
        check("rd2_rvalid0", rvalid0, 0);

        // Contention: both ports requesting continuously
        req0 = 1; we0 = 0; addr0 = 6'h10;
        req1 = 1; we1 = 0; addr1 = 6'h20;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef MEM_ARB_RR_EN
            check("cont_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
            check("cont_gnt1", gnt1, (k % 2 == 0) ? 0 : 1);
`else
            check("cont_gnt0", gnt0, 1);
            check("cont_gnt1", gnt1, 0);
`endif
            step();
            check("cont_resp_gnt0", gnt0, 0);
            check("cont_resp_gnt1", gnt1, 0);
        end
        req0 = 0; req1 = 0;
        step();
        step();
        step();
        check("cont_rdata0", rdata0, 16'h1111);
`ifdef MEM_ARB_RR_EN
        check("cont_rdata1", rdata1, 16'h2222);
`else
        check("cont_rdata1", rdata1, 16'hABCD);
`endif

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_mem_we", mem_we, 0);
        end
        check("idle_rdata0", rdata0, 16'h1111);
`ifdef MEM_ARB_RR_EN
        check("idle_rdata1", rdata1, 16'h2222);
`else
        check("idle_rdata1", rdata1, 16'hABCD);
`endif

        // Reset asserted during the ACCESS cycle of a write
        req0 = 1; we0 = 1; addr0 = 6'h07; wdata0 = 16'h1234;
        step();
        check("mid_mem_we", mem_we, 1);
        check("mid_gnt0", gnt0, 1);
        req0 = 0; we0 = 0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_gnt0", gnt0, 0);
        check("mid_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_rvalid0", rvalid0, 0);
            check("post_rst_rvalid1", rvalid1, 0);
            check("post_rst_busy", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
